// File: rtl/seg_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_pkg
// Purpose  : Shared constants and types for the four-digit display scanner.
// Revision : 1.0 - initial release
// ============================================================================
package seg_display_pkg;

  localparam int NUM_DIGITS          = 4;
  localparam int DIGIT_W             = 4;
  localparam int DISP_W              = 16;
  localparam int DEFAULT_REFRESH_DIV = 100000;

  typedef logic [1:0] digit_idx_t;

endpackage : seg_display_pkg
`default_nettype wire

// File: rtl/refresh_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : refresh_prescaler
// Purpose  : Free-running modulo-REFRESH_DIV counter with a one-cycle tick in
//            the last count of each period. The counter restarts at 0 on reset,
//            so the first period after reset is full length.
// Revision : 1.0 - initial release
// ============================================================================
module refresh_prescaler #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] pcnt_q;
  logic [CNT_W-1:0] pcnt_d;
  logic             w_last;

  assign w_last = (pcnt_q == CNT_LAST);
  assign tick   = w_last;

  // Next count: wrap to zero after the last count of the period.
  always_comb begin
    pcnt_d = w_last ? '0 : pcnt_q + 1'b1;
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule : refresh_prescaler
`default_nettype wire

// File: rtl/seg_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_scanner
// Purpose  : Time-multiplexes a 16-bit shadowed hex value onto a four-digit
//            seven-segment display: digit select, nibble and blank flag, all
//            registered, plus a one-cycle end-of-frame pulse.
// Options  : SEG_SCAN_LZ_BLANK_EN - when defined, leading zeros are blanked
//            (digit 0 is never suppressed).
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_scanner
  import seg_display_pkg::*;
#(
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DISP_W-1:0] value_in,
  input  logic              load,
  input  logic [3:0]        blank_mask,
  output logic [1:0]        en,
  output logic [3:0]        num,
  output logic              blank,
  output logic              frame_done
);

`ifdef SEG_SCAN_LZ_BLANK_EN
  // True when digit k is above digit 0 and it and every higher nibble are zero.
  function automatic logic lz_blank(input digit_idx_t k, input logic [DISP_W-1:0] v);
    logic all_zero;
    all_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(k)) && (v[DIGIT_W*j +: DIGIT_W] != '0)) begin
        all_zero = 1'b0;
      end
    end
    return (k != 2'd0) && all_zero;
  endfunction
`endif

  logic              slot_tick;
  digit_idx_t        idx_q;
  digit_idx_t        idx_d;
  logic [DISP_W-1:0] shadow_q;
  logic [DISP_W-1:0] shadow_d;
  logic              lz_d;
  logic [1:0]        en_q;
  logic [3:0]        num_q;
  logic [3:0]        num_d;
  logic              blank_q;
  logic              blank_d;
  logic              frame_done_q;
  logic              frame_done_d;

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (slot_tick)
  );

`ifdef SEG_SCAN_LZ_BLANK_EN
  assign lz_d = lz_blank(idx_d, shadow_d);
`else
  assign lz_d = 1'b0;
`endif

  // Next digit index, next shadow value, and the outputs derived from both so
  // a load coinciding with a slot change shows the new nibble immediately.
  always_comb begin
    idx_d        = slot_tick ? idx_q + 2'd1 : idx_q;
    shadow_d     = load ? value_in : shadow_q;
    num_d        = shadow_d[{idx_d, 2'b00} +: DIGIT_W];
    blank_d      = blank_mask[idx_d] | lz_d;
    frame_done_d = slot_tick & (idx_q == 2'd3);
  end

  // State and registered outputs, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= 2'd0;
      shadow_q     <= '0;
      en_q         <= 2'd0;
      num_q        <= 4'h0;
      blank_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      en_q         <= idx_d;
      num_q        <= num_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign en         = en_q;
  assign num        = num_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule : seg_display_scanner
`default_nettype wire

// File: tb/tb_seg_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_scanner
// Purpose  : Self-checking bench for seg_display_scanner (REFRESH_DIV = 4)
//            against a cycle-count based reference model.
// Options  : SEG_SCAN_LZ_BLANK_EN - model follows the same build option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_scanner;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = 4'h0;
  logic [1:0]  en;
  logic [3:0]  num;
  logic        blank;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: edges since reset release, shadow, last mask.
  int          m_n      = 0;
  logic [15:0] m_shadow = 16'h0000;
  logic [3:0]  m_mask   = 4'h0;

  seg_display_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .load       (load),
    .blank_mask (blank_mask),
    .en         (en),
    .num        (num),
    .blank      (blank),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Expected {en, num, blank, frame_done} from elapsed cycle count.
  function automatic logic [7:0] model_out();
    int          e;
    logic [15:0] hi;
    logic        lz;
    logic        bl;
    logic        fd;
    logic [3:0]  nib;
    if (m_n == 0) return 8'h00;
    e   = (m_n / DIV) % 4;
    hi  = m_shadow >> (4 * e);
    nib = hi[3:0];
`ifdef SEG_SCAN_LZ_BLANK_EN
    lz  = (e >= 1) && (hi == 16'h0000);
`else
    lz  = 1'b0;
`endif
    bl  = m_mask[e] | lz;
    fd  = (m_n % (4 * DIV)) == 0;
    return {2'(e), nib, bl, fd};
  endfunction

  // Drive inputs at the falling edge, advance one rising edge, update model.
  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] mask);
    @(negedge clk);
    load = ld; value_in = v; blank_mask = mask;
    @(posedge clk);
    m_n++;
    if (ld) m_shadow = v;
    m_mask = mask;
    #1;
  endtask

  task automatic model_reset();
    m_n = 0; m_shadow = 16'h0000; m_mask = 4'h0;
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {en, num, blank, frame_done};
    n_checks++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: got %h required 00", got);
    end
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 16'($urandom), 4'h0);
      got = {en, num, blank, frame_done}; exp = model_out();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL scan_order cyc%0d: got %h required %h", m_n, got, exp);
      end
    end
  endtask

  task automatic test_basic_load();
    logic [7:0] got, exp;
    step(1'b1, 16'hA5C3, 4'h0);
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 16'($urandom), 4'h0);
      got = {en, num, blank, frame_done}; exp = model_out();
      n_checks++;
      if (got !== exp || blank !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_load cyc%0d: got %h required %h", m_n, got, exp);
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [7:0] got, exp;
    logic [15:0] vals [2];
    vals[0] = 16'h0042; vals[1] = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      step(1'b1, vals[k], 4'h0);
      for (int c = 0; c < 18; c++) begin
        step(1'b0, 16'hFFFF, 4'h0);
        got = {en, num, blank, frame_done}; exp = model_out();
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL lz_blank val%0d cyc%0d: got %h required %h", k, m_n, got, exp);
        end
      end
    end
  endtask

  task automatic test_boundary_load();
    int guard = 0;
    while ((m_n % (4 * DIV)) != (DIV - 1) && guard < 64) begin
      step(1'b0, 16'h0000, 4'h0);
      guard++;
    end
    step(1'b1, 16'h1234, 4'h0);
    n_checks++;
    if (en !== 2'd1 || num !== 4'h3 || guard >= 64) begin
      n_fail++;
      $display("FAIL boundary_load: got en=%0d num=%h required en=1 num=3", en, num);
    end
  endtask

  task automatic test_forced_blank();
    logic [7:0] got, exp;
    for (int c = 0; c < 32; c++) begin
      step(1'($urandom), 16'($urandom), 4'b0101);
      got = {en, num, blank, frame_done}; exp = model_out();
      n_checks++;
      if (got !== exp || (blank !== 1'b1 && (en == 2'd0 || en == 2'd2))) begin
        n_fail++;
        $display("FAIL forced_blank cyc%0d: got %h required %h", m_n, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    for (int c = 0; c < 200; c++) begin
      step(($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom));
      got = {en, num, blank, frame_done}; exp = model_out();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %h required %h", m_n, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, exp;
    int guard = 0;
    // Reach the second cycle of the en=2 slot.
    while (!(((m_n / DIV) % 4) == 2 && (m_n % DIV) == 1) && guard < 64) begin
      step(1'b1, 16'hFFFF, 4'hF);
      guard++;
    end
    #2 rst = 1'b1;
    #1;
    got = {en, num, blank, frame_done};
    n_checks++;
    if (got !== 8'h00 || guard >= 64) begin
      n_fail++;
      $display("FAIL async_reset: got %h required 00", got);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 16'h0000, 4'h0);
      got = {en, num, blank, frame_done}; exp = model_out();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL post_reset_slot cyc%0d: got %h required %h", m_n, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_lz_blank();
    test_boundary_load();
    test_forced_blank();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion required completion");
    $fatal(1, "timeout");
  end

endmodule : tb_seg_display_scanner
`default_nettype wire
